// File: rtl/lstm_ctrl_pkg.sv
// Shared types and constants for the LSTM layer control blocks.
// Holds the sequencer state encoding and default ROM geometry.
package lstm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRESENT,
    ST_DONE
  } seq_state_e;

  localparam int SLICES_DEF    = 6;
  localparam int UNITS_NUM_DEF = 5;
  localparam int ROM_AW        = 8;

endpackage

// File: rtl/bias_idx_cnt.sv
// Nested slice/step counter for the bias fetch sequencer.
// clear loads the step bound; advance steps slice, wrapping into step.
module bias_idx_cnt
  import lstm_ctrl_pkg::*;
#(
  parameter int SLICES  = SLICES_DEF,
  parameter int STEPS_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic [STEPS_W-1:0] steps_i,
  input  logic               advance_i,
  output logic [ROM_AW-1:0]  slice_o,
  output logic [STEPS_W-1:0] step_o,
  output logic               wrap_o,
  output logic               last_o
);

  logic [ROM_AW-1:0]  slice_q, slice_d;
  logic [STEPS_W-1:0] step_q, step_d;
  logic [STEPS_W-1:0] steps_q, steps_d;

  assign wrap_o  = (slice_q == ROM_AW'(SLICES - 1));
  assign last_o  = wrap_o &&
                   (step_q == steps_q - STEPS_W'(1));
  assign slice_o = slice_q;
  assign step_o  = step_q;

  always_comb begin
    slice_d = slice_q;
    step_d  = step_q;
    steps_d = steps_q;
    if (clear_i) begin
      slice_d = '0;
      step_d  = '0;
      steps_d = steps_i;
    end else if (advance_i) begin
      if (wrap_o) begin
        slice_d = '0;
        step_d  = step_q + STEPS_W'(1);
      end else begin
        slice_d = slice_q + ROM_AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slice_q <= '0;
      step_q  <= '0;
      steps_q <= '0;
    end else begin
      slice_q <= slice_d;
      step_q  <= step_d;
      steps_q <= steps_d;
    end
  end

endmodule

// File: rtl/bias_fetch_seq.sv
// Output-gate bias ROM sequencer: walks slices per timestep, one beat each.
// Optional stall counter output enabled by BIAS_SEQ_STALL_CNT_EN.
module bias_fetch_seq
  import lstm_ctrl_pkg::*;
#(
  parameter int D_WL      = 24,
  parameter int UNITS_NUM = UNITS_NUM_DEF,
  parameter int SLICES    = SLICES_DEF,
  parameter int STEPS_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [STEPS_W-1:0]        num_steps,
  output logic                      busy,
  output logic                      done,
  output logic [ROM_AW-1:0]         rom_addr,
  input  logic [UNITS_NUM*D_WL-1:0] rom_data,
  output logic                      b_valid,
  input  logic                      b_ready,
  output logic [UNITS_NUM*D_WL-1:0] b_data,
  output logic [ROM_AW-1:0]         b_slice,
`ifdef BIAS_SEQ_STALL_CNT_EN
  output logic [15:0]               stall_cnt,
`endif
  output logic                      b_last
);

  localparam int DW = UNITS_NUM * D_WL;

  seq_state_e state_q, state_d;

  logic [DW-1:0]     data_q, data_d;
  logic [ROM_AW-1:0] bslice_q, bslice_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;

  logic              cnt_clear, cnt_adv, start_acc;
  logic [ROM_AW-1:0] slice;
  logic [STEPS_W-1:0] step;
  logic              wrap, last;

  bias_idx_cnt #(
    .SLICES  (SLICES),
    .STEPS_W (STEPS_W)
  ) u_idx (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (cnt_clear),
    .steps_i   (num_steps),
    .advance_i (cnt_adv),
    .slice_o   (slice),
    .step_o    (step),
    .wrap_o    (wrap),
    .last_o    (last)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bslice_d  = bslice_q;
    last_d    = last_q;
    valid_d   = valid_q;
    cnt_clear = 1'b0;
    cnt_adv   = 1'b0;
    start_acc = 1'b0;
    rom_addr  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          if (num_steps != '0) begin
            cnt_clear = 1'b1;
            state_d   = ST_FETCH;
          end else begin
            state_d   = ST_DONE;
          end
        end
      end
      ST_FETCH: begin
        rom_addr = slice;
        data_d   = rom_data;
        bslice_d = slice;
        last_d   = last;
        valid_d  = 1'b1;
        state_d  = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (b_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = ST_DONE;
          end else begin
            cnt_adv = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      bslice_q <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      bslice_q <= bslice_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
    end
  end

  assign busy    = (state_q == ST_FETCH) ||
                   (state_q == ST_PRESENT);
  assign done    = (state_q == ST_DONE);
  assign b_valid = valid_q;
  assign b_data  = data_q;
  assign b_slice = bslice_q;
  assign b_last  = last_q;

`ifdef BIAS_SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of PRESENT cycles with the datapath stalled.
  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if (state_q == ST_PRESENT && !b_ready &&
                 stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  logic unused_ok;
  assign unused_ok = start_acc ^ wrap ^ (^step);
`endif

endmodule

// File: doc/bias_fetch_seq.md
# bias_fetch_seq

Sequencer for the LSTM output-gate bias ROM. On a start pulse it walks the bias ROM address through every unit slice, once per timestep, for a programmed number of timesteps. It registers each slice's bias vector and hands it to the gate datapath over a valid/ready handshake. It sits between the layer controller (start/done) and the bias ROM plus gate MAC/activation datapath.

## Interface
Parameters:
- D_WL, 24, bias word length in bits
- UNITS_NUM, 5, bias words per ROM entry (units per slice)
- SLICES, 6, ROM entries per timestep; must be ≥1 and ≤256
- STEPS_W, 8, width of timestep count

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a run; sampled only in IDLE
- num_steps  in  STEPS_W  timesteps in the run; sampled with start
- busy  out  1  high in FETCH and PRESENT
- done  out  1  one-cycle pulse when a run completes
- rom_addr  out  8  address to bias ROM (combinational ROM, data valid the same cycle)
- rom_data  in  UNITS_NUM*D_WL  ROM read data
- b_valid  out  1  bias beat valid
- b_ready  in  1  datapath accepts beat
- b_data  out  UNITS_NUM*D_WL  registered bias vector
- b_slice  out  8  slice index of the current beat
- b_last  out  1  high with the final beat of the run

## Operation
- States: IDLE, FETCH, PRESENT, DONE.
- IDLE:
  - If start and num_steps≠0: latch num_steps, clear slice/step counters, go to FETCH.
  - If start and num_steps==0: go to DONE; no beats are issued.
- FETCH (1 cycle):
  - rom_addr = slice counter.
  - b_data ← rom_data, b_slice ← slice.
  - b_last ← (slice==SLICES-1 && step==num_steps-1).
  - b_valid ← 1; go to PRESENT.
- PRESENT: b_valid, b_data, b_slice and b_last are held stable until b_valid && b_ready. On that handshake:
  - b_valid ← 0.
  - If b_last: go to DONE.
  - Else if slice==SLICES-1: slice ← 0, step ← step+1, go to FETCH.
  - Else: slice ← slice+1, go to FETCH.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored and not queued.
- Counters are unsigned and sized to 8 bits (slice) and STEPS_W bits (step). No overflow is possible because termination compares against the latched bounds.
- rom_addr is 0 in every state except FETCH.

## Timing
- Reset values: state IDLE, busy 0, done 0, b_valid 0, b_data 0, b_slice 0, b_last 0, rom_addr 0, all counters 0.
- Reset mid-run aborts immediately: all outputs take reset values at the next edge, and no done is produced.
- start sampled at edge N → FETCH in cycle N+1 → b_valid high from cycle N+2.
- Each beat costs 1 FETCH cycle + ≥1 PRESENT cycle. With b_ready held high, throughput is one beat per 2 cycles.
- A run issues exactly num_steps×SLICES beats.
- done rises the cycle after the last handshake. A new start is accepted the cycle after done.
- num_steps==0: done pulses in cycle N+1 after start at N.

## Configuration
- Macro BIAS_SEQ_STALL_CNT_EN.
- Defined: adds output port stall_cnt [15:0].
  - Cleared on rst and on each accepted start.
  - Increments every PRESENT cycle with b_ready==0.
  - Saturates at 16'hFFFF and holds its value after done.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package lstm_ctrl_pkg holds:
  - the state enum (IDLE/FETCH/PRESENT/DONE)
  - the default SLICES and UNITS_NUM constants
  - the ROM address width constant (8)
- One sub-module, bias_idx_cnt, implements the nested slice/step counter. Interface: clear, advance, wrap flag, last flag.
- The FSM, output registers and stall counter stay in the top module.

## Test plan
- num_steps=1, b_ready=1, start at cycle 0:
  - beats at cycles 2,4,…,12 with b_slice 0..5.
  - b_data equals ROM entries 0..5.
  - b_last only at cycle 12; done at cycle 13.
- num_steps=2, b_ready=1:
  - 12 beats; b_slice wraps 5→0 after beat 6.
  - last handshake at cycle 24; done at 25; busy low at 25.
- Backpressure: b_ready=0 for 3 cycles on beat 2.
  - b_valid, b_data and b_slice stay stable throughout.
  - With the macro defined, stall_cnt=3 at done.
- num_steps=0 → done at cycle 1; b_valid never asserts; busy stays 0.
- start pulsed at cycle 5 during a num_steps=1 run → ignored; exactly 6 beats, one done.
- rst asserted at the 3rd beat's PRESENT cycle:
  - next cycle: b_valid=0, busy=0, rom_addr=0, no done.
  - a subsequent start restarts at b_slice=0.
